// File: rtl/i2c_pkg.sv
// Shared constants and FSM state type for the I2C register-access sequencer.
package i2c_pkg;

    localparam logic [2:0] START_CMD   = 3'b000;
    localparam logic [2:0] WR_CMD      = 3'b001;
    localparam logic [2:0] RD_CMD      = 3'b010;
    localparam logic [2:0] STOP_CMD    = 3'b011;
    localparam logic [2:0] RESTART_CMD = 3'b100;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_DEV_NACK  = 2'b01;
    localparam logic [1:0] ERR_DATA_NACK = 2'b10;

    // din value for the single RD: bit 0 set makes the master NACK the last byte.
    localparam logic [7:0] RD_LAST_DIN = 8'h01;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;

endpackage

// File: rtl/i2c_step_decode.sv
// Maps (rw, step) of a single-register transfer to the master command and byte.
module i2c_step_decode
    import i2c_pkg::*;
(
    input  logic       rw,
    input  logic [2:0] step,
    input  logic [6:0] dev,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [2:0] cmd,
    output logic [7:0] din,
    output logic       is_stop,
    output logic       is_addr_byte,
    output logic       is_rd,
    output logic [2:0] stop_step
);

    always_comb begin
        cmd          = STOP_CMD;
        din          = 8'h00;
        is_addr_byte = 1'b0;
        stop_step    = rw ? 3'd6 : 3'd4;
        if (!rw) begin
            case (step)
                3'd0: cmd = START_CMD;
                3'd1: begin cmd = WR_CMD; din = {dev, 1'b0}; is_addr_byte = 1'b1; end
                3'd2: begin cmd = WR_CMD; din = reg_addr; end
                3'd3: begin cmd = WR_CMD; din = wdata; end
                default: cmd = STOP_CMD;
            endcase
        end else begin
            case (step)
                3'd0: cmd = START_CMD;
                3'd1: begin cmd = WR_CMD; din = {dev, 1'b0}; is_addr_byte = 1'b1; end
                3'd2: begin cmd = WR_CMD; din = reg_addr; end
                3'd3: cmd = RESTART_CMD;
                3'd4: begin cmd = WR_CMD; din = {dev, 1'b1}; is_addr_byte = 1'b1; end
                3'd5: begin cmd = RD_CMD; din = RD_LAST_DIN; end
                default: cmd = STOP_CMD;
            endcase
        end
        is_stop = (cmd == STOP_CMD);
        is_rd   = (cmd == RD_CMD);
    end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Sequences complete single-register I2C writes/reads onto a byte-level master.
// Optional: define I2C_RETRY_EN to retry NACKed requests up to MAX_RETRY times.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter logic [1:0] MAX_RETRY = 2'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic [2:0] cmd,
    output logic [7:0] din,
    output logic       wr_i2c,
    input  logic       m_ready,
    input  logic       m_done_tick,
    input  logic       m_ack,
    input  logic [7:0] m_dout
);

    state_t     state;
    logic [2:0] step;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic       nack_q;

    logic [2:0] dec_cmd;
    logic [7:0] dec_din;
    logic       dec_is_stop;
    logic       dec_is_addr;
    logic       dec_is_rd;
    logic [2:0] dec_stop_step;

    i2c_step_decode u_decode (
        .rw           (rw_q),
        .step         (step),
        .dev          (dev_q),
        .reg_addr     (reg_q),
        .wdata        (wdata_q),
        .cmd          (dec_cmd),
        .din          (dec_din),
        .is_stop      (dec_is_stop),
        .is_addr_byte (dec_is_addr),
        .is_rd        (dec_is_rd),
        .stop_step    (dec_stop_step)
    );

    // A NACK arriving in the same cycle ready returns must still divert to STOP.
    logic byte_nack;
    logic nack_now;
    assign byte_nack = m_done_tick && (dec_cmd == WR_CMD) && m_ack;
    assign nack_now  = nack_q || byte_nack;
    assign req_ready = (state == IDLE);

`ifdef I2C_RETRY_EN
    logic [1:0] retry_cnt;
    logic       retry_go;
    assign retry_go = nack_now && (retry_cnt < MAX_RETRY);
`else
    logic unused_max_retry;
    assign unused_max_retry = ^MAX_RETRY;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            step      <= 3'd0;
            rw_q      <= 1'b0;
            dev_q     <= 7'd0;
            reg_q     <= 8'd0;
            wdata_q   <= 8'd0;
            nack_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_err   <= ERR_OK;
            wr_i2c    <= 1'b0;
            cmd       <= START_CMD;
            din       <= 8'd0;
`ifdef I2C_RETRY_EN
            retry_cnt <= 2'd0;
`endif
        end else begin
            wr_i2c    <= 1'b0;
            rsp_valid <= 1'b0;

            if ((state == WAIT_LO || state == WAIT_HI) && m_done_tick) begin
                if (byte_nack) begin
                    nack_q  <= 1'b1;
                    rsp_err <= dec_is_addr ? ERR_DEV_NACK : ERR_DATA_NACK;
                end
                if (dec_is_rd) rsp_rdata <= m_dout;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rw_q      <= req_rw;
                        dev_q     <= req_dev;
                        reg_q     <= req_reg;
                        wdata_q   <= req_wdata;
                        step      <= 3'd0;
                        nack_q    <= 1'b0;
                        rsp_err   <= ERR_OK;
                        rsp_rdata <= 8'd0;
`ifdef I2C_RETRY_EN
                        retry_cnt <= 2'd0;
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        wr_i2c <= 1'b1;
                        cmd    <= dec_cmd;
                        din    <= dec_din;
                        state  <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!m_ready) state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (m_ready) begin
                        if (dec_is_stop) begin
`ifdef I2C_RETRY_EN
                            if (retry_go) begin
                                retry_cnt <= retry_cnt + 2'd1;
                                rsp_err   <= ERR_OK;
                                nack_q    <= 1'b0;
                                step      <= 3'd0;
                                state     <= ISSUE;
                            end else begin
                                rsp_valid <= 1'b1;
                                state     <= DONE;
                            end
`else
                            rsp_valid <= 1'b1;
                            state     <= DONE;
`endif
                        end else if (nack_now) begin
                            step  <= dec_stop_step;
                            state <= ISSUE;
                        end else begin
                            step  <= step + 3'd1;
                            state <= ISSUE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: byte-level master model plus a transfer-level reference model.
module tb_i2c_reg_ctrl;

    localparam logic [2:0] C_START   = 3'b000;
    localparam logic [2:0] C_WR      = 3'b001;
    localparam logic [2:0] C_RD      = 3'b010;
    localparam logic [2:0] C_STOP    = 3'b011;
    localparam logic [2:0] C_RESTART = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic [2:0] cmd;
    logic [7:0] din;
    logic       wr_i2c;
    logic       m_ready;
    logic       m_done_tick;
    logic       m_ack;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    i2c_reg_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_dev     (req_dev),
        .req_reg     (req_reg),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .cmd         (cmd),
        .din         (din),
        .wr_i2c      (wr_i2c),
        .m_ready     (m_ready),
        .m_done_tick (m_done_tick),
        .m_ack       (m_ack),
        .m_dout      (m_dout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Master model: records every strobed {cmd,din}, then busy/done/ready.
    int         nack_sel;
    logic [7:0] slave_byte;
    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];
    int   busy_cnt;
    bit   busy;
    bit   need_done;
    bit   done_is_rd;
    int   wr_idx;
    logic done_ack;

    initial begin
        m_ready = 1'b1; m_done_tick = 1'b0; m_ack = 1'b0; m_dout = 8'h00;
        busy = 0; need_done = 0; done_is_rd = 0; wr_idx = 0; busy_cnt = 0; done_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_done_tick = 1'b0;
            if (reset) begin
                m_ready = 1'b1; busy = 0; need_done = 0;
            end else if (wr_i2c) begin
                check_eq("strobe_ready", m_ready, 1);
                if (!busy) begin
                    obs_q.push_back({cmd, din});
                    m_ready    = 1'b0;
                    busy       = 1;
                    busy_cnt   = $urandom_range(0, 3);
                    need_done  = (cmd == C_WR) || (cmd == C_RD);
                    done_is_rd = (cmd == C_RD);
                    if (cmd == C_START) wr_idx = 0;
                    if (cmd == C_WR) begin
                        done_ack = (wr_idx == nack_sel);
                        wr_idx++;
                    end else begin
                        done_ack = 1'b1;
                    end
                end
            end else if (busy) begin
                if (busy_cnt > 0) busy_cnt--;
                else if (need_done) begin
                    m_done_tick = 1'b1;
                    m_ack       = done_ack;
                    m_dout      = done_is_rd ? slave_byte : 8'($urandom);
                    need_done   = 0;
                end else begin
                    m_ready = 1'b1;
                    busy    = 0;
                end
            end
        end
    end

    task automatic run_req(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input int nk, input logic [7:0] sb);
        logic [10:0] full[$];
        logic [10:0] o;
        logic [10:0] e;
        logic [1:0]  exp_err;
        logic [7:0]  exp_rdata;
        logic [1:0]  got_err;
        logic [7:0]  got_rdata;
        bit          stopped;
        int          wr_k;
        int          pulses;
        int          cyc;

        // Reference: full transfer, cut short after the NACKed write byte, STOP always last.
        full.push_back({C_START, 8'h00});
        full.push_back({C_WR, dev, 1'b0});
        full.push_back({C_WR, ra});
        if (rw) begin
            full.push_back({C_RESTART, 8'h00});
            full.push_back({C_WR, dev, 1'b1});
            full.push_back({C_RD, 8'h01});
        end else begin
            full.push_back({C_WR, wd});
        end
        exp_q.delete();
        exp_err = 2'b00; wr_k = 0; stopped = 0;
        foreach (full[i]) begin
            if (!stopped) begin
                exp_q.push_back(full[i]);
                if (full[i][10:8] == C_WR) begin
                    if (wr_k == nk) begin
                        exp_err = (wr_k == 0 || (rw && wr_k == 2)) ? 2'b01 : 2'b10;
                        stopped = 1;
                    end
                    wr_k++;
                end
            end
        end
        exp_q.push_back({C_STOP, 8'h00});
        exp_rdata = (rw && exp_err == 2'b00) ? sb : 8'h00;

        nack_sel = nk; slave_byte = sb; obs_q.delete();
        @(negedge clk);
        check_eq("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = ra; req_wdata = wd;
        @(negedge clk);
        check_eq("ready_busy", req_ready, 0);
        // Junk request held for a few cycles; must be ignored while busy.
        req_rw = ~rw; req_dev = 7'($urandom); req_reg = 8'($urandom); req_wdata = 8'($urandom);
        pulses = 0; cyc = 0; got_err = 2'b11; got_rdata = 8'hxx;
        while (cyc < 2000 && !(pulses > 0 && req_ready)) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) req_valid = 1'b0;
            if (rsp_valid) begin
                pulses++;
                got_err   = rsp_err;
                got_rdata = rsp_rdata;
            end
        end
        req_valid = 1'b0;
        check_eq("no_timeout", (cyc < 2000), 1);
        check_eq("rsp_pulses", pulses, 1);
        check_eq("rsp_err", got_err, exp_err);
        check_eq("rsp_rdata", got_rdata, exp_rdata);
        check_eq("cmd_count", obs_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            e = exp_q[i];
            o = (i < obs_q.size()) ? obs_q[i] : 11'h7ff;
            check_eq($sformatf("cmd[%0d]", i), o[10:8], e[10:8]);
            if (e[10:8] == C_WR || e[10:8] == C_RD)
                check_eq($sformatf("din[%0d]", i), o[7:0], e[7:0]);
        end
        @(negedge clk);
        check_eq("err_hold", rsp_err, exp_err);
        check_eq("rdata_hold", rsp_rdata, exp_rdata);
        check_eq("valid_low", rsp_valid, 0);
    endtask

    initial begin
        int cyc;
        int stray;
        int r;
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0;
        req_dev = 7'd0; req_reg = 8'd0; req_wdata = 8'd0;
        nack_sel = -1; slave_byte = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_wr_i2c", wr_i2c, 0);
        check_eq("rst_cmd", cmd, 0);
        check_eq("rst_din", din, 0);
        reset = 1'b0;

        run_req(1'b0, 7'h50, 8'h10, 8'hA5, -1, 8'h00);
        run_req(1'b1, 7'h50, 8'h20, 8'h00, -1, 8'h3C);
        run_req(1'b0, 7'h50, 8'h10, 8'hA5, 0, 8'h00);
        run_req(1'b1, 7'h50, 8'h20, 8'h00, 1, 8'h3C);

        // Reset in the middle of the reg-byte write, then a fresh request.
        nack_sel = -1; obs_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h10; req_wdata = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (obs_q.size() < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_step2", obs_q.size(), 3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("post_rst_ready", req_ready, 1);
        check_eq("post_rst_err", rsp_err, 0);
        stray = 0;
        repeat (5) begin
            if (rsp_valid || wr_i2c) stray++;
            @(negedge clk);
        end
        check_eq("post_rst_quiet", stray, 0);
        run_req(1'b0, 7'h51, 8'h22, 8'h33, -1, 8'h00);

        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 5));
            run_req(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                    (r < 3) ? r : -1, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
